// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a binary-to-BCD client (master) and the converter (slave).
// The client drives start/bin_in; the converter returns busy/done and the registered result.
interface bin_to_bcd_seq_if #(
    parameter int N      = 7,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [N-1:0]          bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  neg;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, neg
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, neg
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: N shift cycles plus one DONE cycle after the accepting edge.
// start is only taken in IDLE; requests arriving while busy are dropped, never queued.
module bin_to_bcd_seq #(
    parameter int N      = 7,
    parameter int DIGITS = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            CPU_RESETN,
    bin_to_bcd_seq_if.slave bus
);
    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]  ONE      = N'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    logic [N-1:0]          shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [CW-1:0]         cnt;
    logic                  sign;
    logic                  busy_r;
    logic                  done_r;
    logic [4*DIGITS-1:0]   bcd_r;
    logic                  neg_r;

    logic                  in_neg;
    logic [N-1:0]          mag;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scr_nxt;
    logic [N-1:0]          bin_nxt;

    // Negating the most negative value wraps to 2^(N-1), which is the correct magnitude as unsigned.
    assign in_neg = SIGNED && bus.bin_in[N-1];
    assign mag    = in_neg ? (~bus.bin_in + ONE) : bus.bin_in;

    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        {scr_nxt, bin_nxt} = {adj, shreg} << 1;
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= '0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shreg   <= mag;
                        scratch <= '0;
                        cnt     <= '0;
                        sign    <= in_neg;
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scr_nxt;
                    shreg   <= bin_nxt;
                    cnt     <= cnt + CW'(1);
                    // The final step's result is published on the same edge that enters DONE.
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        bcd_r  <= scr_nxt;
                        neg_r  <= sign;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bcd_out = bcd_r;
    assign bus.neg     = neg_r;
endmodule
